// File: rtl/seq_mult_ctrl_if.sv
// Handshake and datapath-control bundle for the shift-add multiplier controller.
// The master side is the controller; the slave side is the top level plus the datapath.
interface seq_mult_ctrl_if #(
  parameter int SIZE = 4
);
  localparam int CW = $clog2(SIZE) + 1;

  logic          start;
  logic          abort;
  logic          lsb;
  logic          load_op;
  logic          clear_acc;
  logic          acc_load;
  logic          acc_shift;
  logic          q_shift;
  logic          busy;
  logic          done;
  logic [CW-1:0] iter;

  modport master (
    input  start, abort, lsb,
    output load_op, clear_acc, acc_load, acc_shift, q_shift, busy, done, iter
  );

  modport slave (
    output start, abort, lsb,
    input  load_op, clear_acc, acc_load, acc_shift, q_shift, busy, done, iter
  );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Control FSM for a shift-add sequential multiplier: load/clear, SIZE add-shift
// iterations, then a one-cycle done pulse.
module seq_mult_ctrl #(
  parameter int SIZE = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_mult_ctrl_if.master    bus
);
  localparam int CW = $clog2(SIZE) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] iter_reg, iter_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      iter_reg  <= '0;
    end else begin
      state_reg <= state_next;
      iter_reg  <= iter_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    iter_next  = iter_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = INIT;
        end
      end
      INIT: begin
        iter_next  = '0;
        state_next = ITER;
        if (bus.abort) begin
          state_next = IDLE;
        end
      end
      ITER: begin
        iter_next = iter_reg + 1'b1;
        if (iter_reg == CW'(SIZE - 1)) begin
          state_next = DONE;
        end
        // Abort wins over the normal advance and discards the partial count.
        if (bus.abort) begin
          state_next = IDLE;
          iter_next  = '0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        iter_next  = '0;
      end
    endcase
  end

  // Everything except acc_load is a pure decode of the registered state.
  always_comb begin
    bus.load_op   = 1'b0;
    bus.clear_acc = 1'b0;
    bus.acc_shift = 1'b0;
    bus.q_shift   = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state_reg)
      INIT: begin
        bus.load_op   = 1'b1;
        bus.clear_acc = 1'b1;
        bus.busy      = 1'b1;
      end
      ITER: begin
        bus.acc_shift = 1'b1;
        bus.q_shift   = 1'b1;
        bus.busy      = 1'b1;
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.acc_load = (state_reg == ITER) & bus.lsb;
  assign bus.iter     = iter_reg;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench: three controllers (SIZE 4, 8, 2) each driving a behavioural shift-add datapath;
// products are checked against a queue of expected values pushed at start time.
module tb_seq_mult_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam int NI = 3;
  int sizes [NI] = '{4, 8, 2};

  logic       start_a   [NI];
  logic       abort_a   [NI];
  logic [7:0] mcand_a   [NI];
  logic [7:0] mplier_a  [NI];
  logic       load_a    [NI];
  logic       clear_a   [NI];
  logic       ashift_a  [NI];
  logic       aload_a   [NI];
  logic       qshift_a  [NI];
  logic       busy_a    [NI];
  logic       done_a    [NI];
  logic [3:0] iter_a    [NI];
  logic [15:0] prod_a   [NI];

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q [$];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_inst
      localparam int SZ = (gi == 0) ? 4 : ((gi == 1) ? 8 : 2);
      seq_mult_ctrl_if #(.SIZE(SZ)) bus ();
      seq_mult_ctrl #(.SIZE(SZ)) dut (.clk(clk), .rst(rst), .bus(bus));

      logic [SZ-1:0] a_reg, acc_reg, q_reg;
      logic [SZ:0]   sum;
      assign sum       = {1'b0, acc_reg} + {1'b0, a_reg};
      assign bus.lsb   = q_reg[0];
      assign bus.start = start_a[gi];
      assign bus.abort = abort_a[gi];

      always_ff @(posedge clk) begin
        if (bus.load_op) begin
          a_reg <= mcand_a[gi][SZ-1:0];
          q_reg <= mplier_a[gi][SZ-1:0];
        end else if (bus.q_shift) begin
          q_reg <= {(bus.acc_load ? sum[0] : acc_reg[0]), q_reg[SZ-1:1]};
        end
        if (bus.clear_acc) acc_reg <= '0;
        else if (bus.acc_shift) acc_reg <= bus.acc_load ? sum[SZ:1] : {1'b0, acc_reg[SZ-1:1]};
      end

      assign load_a[gi]   = bus.load_op;
      assign clear_a[gi]  = bus.clear_acc;
      assign ashift_a[gi] = bus.acc_shift;
      assign aload_a[gi]  = bus.acc_load;
      assign qshift_a[gi] = bus.q_shift;
      assign busy_a[gi]   = bus.busy;
      assign done_a[gi]   = bus.done;
      assign iter_a[gi]   = 4'(bus.iter);
      assign prod_a[gi]   = 16'({acc_reg, q_reg});
    end
  endgenerate

  function automatic logic [10:0] outs(input int idx);
    return {load_a[idx], clear_a[idx], ashift_a[idx], aload_a[idx], qshift_a[idx],
            busy_a[idx], done_a[idx], iter_a[idx]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      start_a[i] = 1'b1; abort_a[i] = 1'b0; mcand_a[i] = '0; mplier_a[i] = '0;
    end
    rst = 1'b1;
    tick(); tick();
    for (int i = 0; i < NI; i++) begin
      tests++;
      if (outs(i) !== 11'd0) begin
        fails++;
        $display("FAIL reset_outputs inst%0d: got %b expected 0", i, outs(i));
      end
      start_a[i] = 1'b0;
    end
    rst = 1'b0;
    tick();
    $display("[TB] reset checked");
  endtask

  // Single operation; expected product goes to the queue at start, popped at done.
  task automatic run_op(input int idx, input logic [7:0] mc, input logic [7:0] mp,
                        input logic [7:0] exp_pat);
    logic [15:0] e, got_p;
    logic [7:0]  pat;
    int n, shifts, loads;
    bit got;
    e = mc * mp;
    mcand_a[idx] = mc; mplier_a[idx] = mp; start_a[idx] = 1'b1;
    exp_q.push_back(e);
    pat = '0; n = 0; shifts = 0; loads = 0; got = 0;
    while (n < 40 && !got) begin
      tick();
      n++;
      start_a[idx] = 1'b0;
      if (load_a[idx]) loads++;
      if (ashift_a[idx]) begin
        if (aload_a[idx] && shifts < 8) pat[shifts] = 1'b1;
        shifts++;
      end
      if (done_a[idx]) got = 1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL done_timeout inst%0d: no done within %0d cycles", idx, n);
      return;
    end
    got_p = exp_q.pop_front();
    tests++;
    if (prod_a[idx] !== got_p) begin
      fails++;
      $display("FAIL product inst%0d: got %0d expected %0d", idx, prod_a[idx], got_p);
    end
    tests++;
    if (n != sizes[idx] + 2) begin
      fails++;
      $display("FAIL latency inst%0d: got %0d expected %0d", idx, n, sizes[idx] + 2);
    end
    tests++;
    if (shifts != sizes[idx] || loads != 1) begin
      fails++;
      $display("FAIL shift_load_count inst%0d: shifts %0d loads %0d expected %0d and 1",
               idx, shifts, loads, sizes[idx]);
    end
    tests++;
    if (iter_a[idx] !== 4'(sizes[idx]) || busy_a[idx] !== 1'b0) begin
      fails++;
      $display("FAIL done_iter inst%0d: iter %0d busy %b expected %0d and 0",
               idx, iter_a[idx], busy_a[idx], sizes[idx]);
    end
    if (idx == 0) begin
      tests++;
      if (pat !== exp_pat) begin
        fails++;
        $display("FAIL acc_load_pattern: got %b expected %b", pat, exp_pat);
      end
    end
    tick();
    tests++;
    if (busy_a[idx] !== 1'b0 || done_a[idx] !== 1'b0) begin
      fails++;
      $display("FAIL post_done_idle inst%0d: busy %b done %b expected 0 0",
               idx, busy_a[idx], done_a[idx]);
    end
    $display("[TB] op inst%0d %0d x %0d -> %0d in %0d cycles", idx, mc, mp, prod_a[idx], n);
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    int dones;
    logic exp_busy, exp_done;
    mcand_a[0] = 8'd5; mplier_a[0] = 8'd7;
    start_a[0] = 1'b1;
    exp_q.push_back(16'd35);
    dones = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp_busy = (c % 7) >= 1 && (c % 7) <= 5;
      exp_done = (c % 7) == 6;
      tests++;
      if (busy_a[0] !== exp_busy || done_a[0] !== exp_done) begin
        fails++;
        $display("FAIL b2b_cycle%0d: busy %b done %b expected %b %b",
                 c, busy_a[0], done_a[0], exp_busy, exp_done);
      end
      if (done_a[0] === 1'b1) begin
        dones++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_unexpected_done cycle%0d: got done expected none queued", c);
        end else begin
          e = exp_q.pop_front();
          if (prod_a[0] !== e) begin
            fails++;
            $display("FAIL b2b_product cycle%0d: got %0d expected %0d", c, prod_a[0], e);
          end
        end
      end
      if (c < 20 && c % 7 == 0) exp_q.push_back(16'd35);
      start_a[0] = (c < 20);
    end
    tests++;
    if (dones != 3 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_done_count: got %0d dones, %0d left expected 3, 0", dones, exp_q.size());
    end
    tick();
    $display("[TB] back_to_back done pulses %0d", dones);
  endtask

  task automatic test_abort();
    int spurious;
    mcand_a[0] = 8'd9; mplier_a[0] = 8'd6; start_a[0] = 1'b1;
    tick(); start_a[0] = 1'b0;
    tick(); tick();
    abort_a[0] = 1'b1;
    #1;
    tests++;
    if (ashift_a[0] !== 1'b1 || busy_a[0] !== 1'b1) begin
      fails++;
      $display("FAIL abort_cycle_outputs: acc_shift %b busy %b expected 1 1", ashift_a[0], busy_a[0]);
    end
    tick();
    abort_a[0] = 1'b0;
    tests++;
    if (outs(0) !== 11'd0) begin
      fails++;
      $display("FAIL abort_idle: got %b expected 0", outs(0));
    end
    spurious = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done_a[0] !== 1'b0 || busy_a[0] !== 1'b0) spurious++;
    end
    tests++;
    if (spurious != 0) begin
      fails++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", spurious);
    end
    $display("[TB] abort checked");
    run_op(0, 8'd9, 8'd6, 8'b0000_0110);
  endtask

  task automatic test_reset_mid_op();
    mcand_a[0] = 8'd13; mplier_a[0] = 8'd11; start_a[0] = 1'b1;
    tick(); start_a[0] = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; abort_a[0] = 1'b1; start_a[0] = 1'b1;
    tick();
    tests++;
    if (outs(0) !== 11'd0) begin
      fails++;
      $display("FAIL reset_mid_op: got %b expected 0", outs(0));
    end
    rst = 1'b0; abort_a[0] = 1'b0; start_a[0] = 1'b0;
    tick();
    tests++;
    if (outs(0) !== 11'd0) begin
      fails++;
      $display("FAIL reset_start_ignored: got %b expected 0", outs(0));
    end
    $display("[TB] reset mid-operation checked");
  endtask

  initial begin
    test_reset();
    run_op(0, 8'd13, 8'd11, 8'b0000_1011);
    run_op(0, 8'd13, 8'd0,  8'b0000_0000);
    run_op(0, 8'd15, 8'd15, 8'b0000_1111);
    test_back_to_back();
    test_abort();
    test_reset_mid_op();
    run_op(1, 8'd255, 8'd255, 8'd0);
    run_op(2, 8'd3,   8'd3,   8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
